// File: rtl/vga_plot_arbiter_pkg.sv
// Shared defaults for the VGA plot arbiter: coordinate/colour widths, the
// 320x240 visible area and the frame-clear FSM state encoding.
package vga_plot_arbiter_pkg;

  localparam int PKG_X_W     = 9;
  localparam int PKG_Y_W     = 8;
  localparam int PKG_COLOR_W = 3;
  localparam int PKG_H_RES   = 320;
  localparam int PKG_V_RES   = 240;

  typedef enum logic {
    CLR_IDLE  = 1'b0,
    CLR_SWEEP = 1'b1
  } clr_state_e;

  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vga_plot_arbiter_plot_fifo.sv
// Single-clock FIFO for one plot source; status comes from registered
// occupancy only, and the head entry is readable without a pop.
module plot_fifo #(
  parameter int WIDTH = 20,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full    = (cnt_q == FULL_CNT);
  assign empty   = (cnt_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr_q];

  always_comb begin
    wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push && !do_pop) cnt_d = cnt_q + 1'b1;
    else if (do_pop && !do_push) cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/vga_plot_arbiter.sv
// Round-robin pixel arbiter feeding vga_adapter, with off-screen clipping.
// Define VGA_PLOT_ARB_CLEAR_EN to compile in the full-frame clear sweep.
module vga_plot_arbiter
  import vga_plot_arbiter_pkg::*;
#(
  parameter int NUM_SRC    = 2,
  parameter int X_W        = PKG_X_W,
  parameter int Y_W        = PKG_Y_W,
  parameter int COLOR_W    = PKG_COLOR_W,
  parameter int H_RES      = PKG_H_RES,
  parameter int V_RES      = PKG_V_RES,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                       CLOCK_50,
  input  logic                       resetn,
  input  logic [NUM_SRC*X_W-1:0]     src_x,
  input  logic [NUM_SRC*Y_W-1:0]     src_y,
  input  logic [NUM_SRC*COLOR_W-1:0] src_colour,
  input  logic [NUM_SRC-1:0]         src_plot,
  output logic [NUM_SRC-1:0]         src_ready,
  input  logic                       clear_req,
  input  logic [COLOR_W-1:0]         clear_colour,
  output logic                       clear_busy,
  output logic                       clear_done,
  output logic [X_W-1:0]             x,
  output logic [Y_W-1:0]             y,
  output logic [COLOR_W-1:0]         colour,
  output logic                       plot,
  output logic [15:0]                drop_cnt
);

  localparam int EW = X_W + Y_W + COLOR_W;
  localparam int GW = sel_width(NUM_SRC);
  localparam logic [X_W:0] H_LIM = (X_W+1)'(H_RES);
  localparam logic [Y_W:0] V_LIM = (Y_W+1)'(V_RES);

  logic [EW-1:0]      fifo_dout [NUM_SRC];
  logic [NUM_SRC-1:0] fifo_full, fifo_empty, pop_vec;
  logic [GW-1:0]      win, cand;
  logic               found, arb_en, stall, sweep_emit, onscreen;
  logic [EW-1:0]      win_entry;
  logic [X_W-1:0]     ex, sw_x;
  logic [Y_W-1:0]     ey, sw_y;
  logic [COLOR_W-1:0] ec, sw_c;

  logic [X_W-1:0]     x_q;
  logic [Y_W-1:0]     y_q;
  logic [COLOR_W-1:0] colour_q;
  logic               plot_q;
  logic [15:0]        drop_q, drop_d;
  logic [GW-1:0]      lg_q;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
      plot_fifo #(.WIDTH(EW), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (CLOCK_50),
        .rst_n (resetn),
        .push  (src_plot[gi]),
        .pop   (pop_vec[gi]),
        .din   ({src_x[gi*X_W +: X_W], src_y[gi*Y_W +: Y_W],
                 src_colour[gi*COLOR_W +: COLOR_W]}),
        .dout  (fifo_dout[gi]),
        .full  (fifo_full[gi]),
        .empty (fifo_empty[gi])
      );
      assign src_ready[gi] = ~fifo_full[gi];
      assign pop_vec[gi]   = arb_en && (win == GW'(gi));
    end
  endgenerate

  // Search starts one past the last winner so every source gets a turn.
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      cand = GW'((int'(lg_q) + 1 + k) % NUM_SRC);
      if (!found && !fifo_empty[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  assign arb_en    = found && !stall;
  assign win_entry = fifo_dout[win];
  assign ex        = win_entry[EW-1 -: X_W];
  assign ey        = win_entry[COLOR_W +: Y_W];
  assign ec        = win_entry[COLOR_W-1:0];
  assign onscreen  = ({1'b0, ex} < H_LIM) && ({1'b0, ey} < V_LIM);

  always_comb begin
    drop_d = drop_q;
    if (arb_en && !onscreen && drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
  end

`ifdef VGA_PLOT_ARB_CLEAR_EN
  localparam logic [X_W-1:0] X_LAST = X_W'(H_RES - 1);
  localparam logic [Y_W-1:0] Y_LAST = Y_W'(V_RES - 1);

  clr_state_e         state_q;
  logic [X_W-1:0]     cx_q;
  logic [Y_W-1:0]     cy_q;
  logic [COLOR_W-1:0] fill_q;
  logic               fin_q, busy_q, done_q;

  // fin_q marks the cycle after the last pixel, where done pulses.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state_q <= CLR_IDLE;
      cx_q    <= '0;
      cy_q    <= '0;
      fill_q  <= '0;
      fin_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        CLR_IDLE: begin
          if (clear_req) begin
            state_q <= CLR_SWEEP;
            cx_q    <= '0;
            cy_q    <= '0;
            fill_q  <= clear_colour;
            fin_q   <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        CLR_SWEEP: begin
          if (fin_q) begin
            state_q <= CLR_IDLE;
            fin_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else if (cx_q == X_LAST) begin
            cx_q <= '0;
            cy_q <= cy_q + 1'b1;
            if (cy_q == Y_LAST) fin_q <= 1'b1;
          end else begin
            cx_q <= cx_q + 1'b1;
          end
        end
      endcase
    end
  end

  assign stall      = (state_q == CLR_SWEEP);
  assign sweep_emit = (state_q == CLR_SWEEP) && !fin_q;
  assign sw_x       = cx_q;
  assign sw_y       = cy_q;
  assign sw_c       = fill_q;
  assign clear_busy = busy_q;
  assign clear_done = done_q;
`else
  logic unused_clear;
  assign unused_clear = ^{clear_req, clear_colour};
  assign stall      = 1'b0;
  assign sweep_emit = 1'b0;
  assign sw_x       = '0;
  assign sw_y       = '0;
  assign sw_c       = '0;
  assign clear_busy = 1'b0;
  assign clear_done = 1'b0;
`endif

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      x_q      <= '0;
      y_q      <= '0;
      colour_q <= '0;
      plot_q   <= 1'b0;
      drop_q   <= '0;
      lg_q     <= GW'(NUM_SRC - 1);
    end else begin
      plot_q <= 1'b0;
      drop_q <= drop_d;
      if (sweep_emit) begin
        x_q      <= sw_x;
        y_q      <= sw_y;
        colour_q <= sw_c;
        plot_q   <= 1'b1;
      end else if (arb_en) begin
        x_q      <= ex;
        y_q      <= ey;
        colour_q <= ec;
        plot_q   <= onscreen;
        lg_q     <= win;
      end
    end
  end

  assign x        = x_q;
  assign y        = y_q;
  assign colour   = colour_q;
  assign plot     = plot_q;
  assign drop_cnt = drop_q;

endmodule

// File: tb/tb_vga_plot_arbiter.sv
// Scoreboard bench for vga_plot_arbiter; clear-sweep checks are compiled
// only when VGA_PLOT_ARB_CLEAR_EN is defined.
module tb_vga_plot_arbiter;

  typedef struct packed {
    logic [8:0] x;
    logic [7:0] y;
    logic [2:0] c;
  } pix_t;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [17:0] src_x = '0;
  logic [15:0] src_y = '0;
  logic [5:0]  src_colour = '0;
  logic [1:0]  src_plot = '0;
  logic [1:0]  src_ready;
  logic        clear_req = 1'b0;
  logic [2:0]  clear_colour = '0;
  logic        clear_busy, clear_done;
  logic [8:0]  x;
  logic [7:0]  y;
  logic [2:0]  colour;
  logic        plot;
  logic [15:0] drop_cnt;

  int   checks = 0;
  int   errors = 0;
  int   plot_cnt = 0;
  pix_t exp_q [$];
  bit   sweep_mode = 0;
  bit   done_chk = 0;
  bit   done_seen = 0;
  int   sweep_idx = 0;

  always #5 clk = ~clk;

  vga_plot_arbiter dut (
    .CLOCK_50     (clk),
    .resetn       (resetn),
    .src_x        (src_x),
    .src_y        (src_y),
    .src_colour   (src_colour),
    .src_plot     (src_plot),
    .src_ready    (src_ready),
    .clear_req    (clear_req),
    .clear_colour (clear_colour),
    .clear_busy   (clear_busy),
    .clear_done   (clear_done),
    .x            (x),
    .y            (y),
    .colour       (colour),
    .plot         (plot),
    .drop_cnt     (drop_cnt)
  );

  // Monitor: pops the scoreboard on every plot cycle.
  always @(negedge clk) begin
    if (resetn) begin
      if (sweep_mode) begin
        if (plot) begin
          checks++;
          if (x !== 9'(sweep_idx % 320) || y !== 8'(sweep_idx / 320) || colour !== 3'd7) begin
            errors++;
            $display("FAIL sweep_pix idx=%0d got=(%0d,%0d,%0d) want=(%0d,%0d,7)",
                     sweep_idx, x, y, colour, sweep_idx % 320, sweep_idx / 320);
          end
          sweep_idx++;
          if (sweep_idx == 76800) begin
            sweep_mode = 0;
            done_chk   = 1;
            $display("sweep complete: %0d pixels", sweep_idx);
          end
        end else if (sweep_idx > 0) begin
          checks++;
          errors++;
          $display("FAIL sweep_gap idx=%0d got plot=0 want plot=1", sweep_idx);
        end
      end else if (done_chk) begin
        checks++;
        done_chk = 0;
        done_seen = 1;
        if (clear_done !== 1'b1 || clear_busy !== 1'b0 || plot !== 1'b0) begin
          errors++;
          $display("FAIL clear_done_pulse got done=%0b busy=%0b plot=%0b want 1,0,0",
                   clear_done, clear_busy, plot);
        end else $display("clear_done pulse seen");
      end else if (plot) begin
        plot_cnt++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_plot got=(%0d,%0d,%0d) want none", x, y, colour);
        end else begin
          pix_t e;
          e = exp_q.pop_front();
          if (x !== e.x || y !== e.y || colour !== e.c) begin
            errors++;
            $display("FAIL plot_data got=(%0d,%0d,%0d) want=(%0d,%0d,%0d)",
                     x, y, colour, e.x, e.y, e.c);
          end else $display("plot (%0d,%0d,%0d) ok", x, y, colour);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", name, act, want);
    end else $display("check %s = %0h ok", name, act);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_src(input int s, input logic [8:0] xv, input logic [7:0] yv,
                         input logic [2:0] cv);
    if (s == 0) begin
      src_x[8:0] = xv; src_y[7:0] = yv; src_colour[2:0] = cv; src_plot[0] = 1'b1;
    end else begin
      src_x[17:9] = xv; src_y[15:8] = yv; src_colour[5:3] = cv; src_plot[1] = 1'b1;
    end
  endtask

  task automatic expect_pix(input logic [8:0] xv, input logic [7:0] yv, input logic [2:0] cv);
    pix_t p;
    p.x = xv; p.y = yv; p.c = cv;
    exp_q.push_back(p);
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_plot"},  32'(plot), 32'd0);
    chk({tag, "_xyc"},   32'({x, y, colour}), 32'd0);
    chk({tag, "_ready"}, 32'(src_ready), 32'd3);
    chk({tag, "_busy"},  32'({clear_busy, clear_done}), 32'd0);
    chk({tag, "_drop"},  32'(drop_cnt), 32'd0);
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_state("rst");
    resetn = 1'b1;
    cyc();
  endtask

  task automatic wait_drain(input int bound);
    int n = 0;
    while (exp_q.size() != 0 && n < bound) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("drain_done", 32'(exp_q.size()), 32'd0);
    cyc();
  endtask

  task automatic lat_test(input int s, input logic [8:0] xv, input logic [7:0] yv,
                          input logic [2:0] cv);
    set_src(s, xv, yv, cv);
    expect_pix(xv, yv, cv);
    @(posedge clk);
    #1 src_plot = '0;
    @(negedge clk);
    chk("lat_after_e0", 32'(plot), 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("lat_after_e1", 32'(plot), 32'd1);
    cyc();
  endtask

  initial begin
    int p0;
    int n;

    // 1: single pixel, 2-edge latency
    do_reset();
    lat_test(0, 9'd5, 8'd7, 3'b101);
    wait_drain(20);
    chk("drop_zero", 32'(drop_cnt), 32'd0);

    // 2: both sources backlogged, strict alternation from source 0
    do_reset();
    p0 = plot_cnt;
    for (int k = 0; k < 4; k++) begin
      set_src(0, 9'(10 + k), 8'(20 + k), 3'(k));
      set_src(1, 9'(100 + k), 8'(50 + k), 3'(7 - k));
      expect_pix(9'(10 + k), 8'(20 + k), 3'(k));
      expect_pix(9'(100 + k), 8'(50 + k), 3'(7 - k));
      cyc();
    end
    src_plot = '0;
    repeat (6) cyc();
    chk("rr_consec_cnt", 32'(plot_cnt - p0), 32'd8);
    chk("rr_idle_after", 32'(plot), 32'd0);
    wait_drain(20);

    // 3: both pushing every cycle; FIFO 1 fills after edge 13
    do_reset();
    for (int k = 0; k < 14; k++) begin
      set_src(0, 9'(k), 8'd1, 3'd1);
      set_src(1, 9'(k), 8'd2, 3'd2);
      expect_pix(9'(k), 8'd1, 3'd1);
      expect_pix(9'(k), 8'd2, 3'd2);
      cyc();
      if (k == 12) chk("ready_before_full", 32'(src_ready), 32'd3);
      if (k == 13) chk("ready_full", 32'(src_ready), 32'd1);
    end
    src_plot = '0;
    cyc();
    chk("ready_rise", 32'(src_ready), 32'd3);
    wait_drain(60);

    // 4: clipping
    do_reset();
    set_src(0, 9'd320, 8'd0, 3'd1);   cyc();
    set_src(0, 9'd0, 8'd240, 3'd2);   cyc();
    set_src(0, 9'd319, 8'd239, 3'd6); cyc();
    expect_pix(9'd319, 8'd239, 3'd6);
    src_plot = '0;
    wait_drain(20);
    chk("drop_two", 32'(drop_cnt), 32'd2);

    // 5: asynchronous reset mid-drain (mid-sweep when clear is compiled in)
`ifdef VGA_PLOT_ARB_CLEAR_EN
    sweep_idx = 0;
    sweep_mode = 1;
    clear_colour = 3'd7;
    clear_req = 1'b1;
    cyc();
    clear_req = 1'b0;
`endif
    for (int k = 0; k < 4; k++) begin
      set_src(0, 9'(40 + k), 8'd9, 3'd3);
      set_src(1, 9'(60 + k), 8'd9, 3'd4);
      expect_pix(9'(60 + k), 8'd9, 3'd4);
      expect_pix(9'(40 + k), 8'd9, 3'd3);
      cyc();
    end
    src_plot = '0;
    cyc();
    cyc();
    resetn = 1'b0;
    #1;
    check_reset_state("async_rst");
    exp_q.delete();
    sweep_mode = 0;
    done_chk = 0;
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    cyc();
    lat_test(1, 9'd33, 8'd44, 3'd2);
    wait_drain(20);

`ifdef VGA_PLOT_ARB_CLEAR_EN
    // 6: full clear sweep, FIFO fills while stalled, second request ignored
    do_reset();
    sweep_idx = 0;
    sweep_mode = 1;
    done_seen = 0;
    clear_colour = 3'd7;
    clear_req = 1'b1;
    cyc();
    clear_req = 1'b0;
    clear_colour = 3'd0;
    chk("clear_busy_hi", 32'(clear_busy), 32'd1);
    for (int k = 0; k < 8; k++) begin
      set_src(1, 9'(k), 8'd3, 3'd4);
      expect_pix(9'(k), 8'd3, 3'd4);
      cyc();
    end
    chk("ready_full_sweep", 32'(src_ready), 32'd1);
    set_src(1, 9'd8, 8'd3, 3'd4);
    expect_pix(9'd8, 8'd3, 3'd4);
    clear_req = 1'b1;
    cyc();
    clear_req = 1'b0;
    n = 0;
    while (!src_ready[1] && n < 80000) begin
      cyc();
      n++;
    end
    chk("ninth_timeout", 32'(n < 80000), 32'd1);
    cyc();
    src_plot = '0;
    wait_drain(200);
    chk("clear_done_seen", 32'(done_seen), 32'd1);
    chk("clear_busy_lo", 32'(clear_busy), 32'd0);
`else
    // 6: clear request has no effect when the sweep is not compiled in
    set_src(0, 9'd1, 8'd2, 3'd3);
    expect_pix(9'd1, 8'd2, 3'd3);
    clear_colour = 3'd7;
    clear_req = 1'b1;
    cyc();
    clear_req = 1'b0;
    src_plot = '0;
    chk("clear_ignored_busy", 32'(clear_busy), 32'd0);
    wait_drain(20);
    chk("clear_ignored_done", 32'({clear_busy, clear_done}), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_plot_arbiter.md
# vga_plot_arbiter

Multi-source pixel arbiter between pixel renderers (HTML parser/renderer and future overlay/cursor sources) and the single `vga_adapter` instance. Each of `NUM_SRC` sources pushes plot requests into its own FIFO. A round-robin arbiter drains the FIFOs at one pixel per clock onto the adapter's `x`/`y`/`colour`/`plot` inputs, discarding off-screen pixels. An optional sweep engine clears the whole frame to a chosen colour.

## Interface
- `NUM_SRC`, 2: number of plot sources (1..8)
- `X_W`, 9: x coordinate width
- `Y_W`, 8: y coordinate width
- `COLOR_W`, 3: colour width (1 bit per channel)
- `H_RES`, 320: visible width; x ≥ `H_RES` is off-screen
- `V_RES`, 240: visible height; y ≥ `V_RES` is off-screen
- `FIFO_DEPTH`, 8: entries per source FIFO (power of two, ≥ 2)

Ports:
- `CLOCK_50` in 1: system clock, all logic on posedge
- `resetn` in 1: asynchronous, active-low reset
- `src_x` in `NUM_SRC*X_W`: packed x; source i occupies `[i*X_W +: X_W]`
- `src_y` in `NUM_SRC*Y_W`: packed y
- `src_colour` in `NUM_SRC*COLOR_W`: packed colour
- `src_plot` in `NUM_SRC`: per-source request valid
- `src_ready` out `NUM_SRC`: per-source FIFO not full
- `clear_req` in 1: single-cycle pulse that starts a frame clear
- `clear_colour` in `COLOR_W`: fill colour, sampled on accepted `clear_req`
- `clear_busy` out 1: sweep in progress
- `clear_done` out 1: one-cycle pulse after the last clear pixel
- `x` out `X_W`, `y` out `Y_W`, `colour` out `COLOR_W`, `plot` out 1: registered outputs to `vga_adapter`
- `drop_cnt` out 16: saturating count of discarded off-screen pixels

## Operation
- Push: source i is accepted on a clock edge where `src_plot[i] & src_ready[i]`. The entry {x,y,colour} is written to FIFO i.
- `src_ready[i]` = FIFO i not full. It is decoded from registered occupancy only. There is no bypass.
- Arbiter: each cycle with no clear active, it picks the first non-empty FIFO at or after `last_grant+1` (mod `NUM_SRC`).
  - It pops that FIFO and registers the entry on the output.
  - `last_grant` updates to the winner.
  - With no FIFO non-empty, `plot` = 0 and `last_grant` holds.
- Clipping: if the popped x ≥ `H_RES` or y ≥ `V_RES`, the output `plot` stays 0 and `drop_cnt` increments, saturating at 0xFFFF.
- Clear FSM: states IDLE and SWEEP.
  - IDLE→SWEEP on `clear_req`. This also latches `clear_colour` and resets the sweep counters to (0,0).
  - In SWEEP, it emits one pixel per cycle in row-major order: x 0..`H_RES`-1, then y+1.
  - After (`H_RES`-1, `V_RES`-1) it returns to IDLE and pulses `clear_done`.
- While SWEEP is active:
  - FIFOs keep accepting pushes but are not popped.
  - `clear_req` is ignored.
- Reset values: `x`, `y`, `colour`, `plot`, `clear_busy`, `clear_done` = 0; `drop_cnt` = 0; `src_ready` all 1; FIFOs empty; `last_grant` = `NUM_SRC`-1 (so source 0 wins first); FSM in IDLE.
- Reset asserted mid-sweep or mid-drain aborts immediately. All queued pixels are lost.

## Timing
- Push accepted at edge E0. The earliest `plot` is high in the cycle following E1, when the pop happens: 2-edge latency.
- Throughput: 1 pixel/cycle aggregate. With all sources backlogged, each gets 1 pixel per `NUM_SRC` cycles.
- Full FIFO: `src_ready` low from the edge that fills it. It rises the edge after a pop.
- Clear:
  - `clear_req` at edge C0 → `clear_busy` high after C0.
  - First clear pixel (0,0) with `plot` = 1 after C1.
  - `H_RES*V_RES` consecutive plot cycles.
  - `clear_done` high and `clear_busy` low in the cycle after the final pixel.
  - Arbitration resumes the next cycle.
- `clear_req` in the same cycle as a pending pop: clear wins from C1. The pop at C0 still completes.

## Configuration
- `VGA_PLOT_ARB_CLEAR_EN` defined: clear FSM, counters and colour latch are compiled in, as described above.
- Not defined:
  - `clear_req` and `clear_colour` are ignored.
  - `clear_busy` and `clear_done` are tied 0.
  - The arbiter never stalls.

## Structure
- Shared package/header holds:
  - `X_W`/`Y_W`/`COLOR_W` defaults matching the existing bit-range macros.
  - `H_RES`/`V_RES` for the 320x240 mode.
  - The clear FSM state encodings.
- Sub-module `plot_fifo`: single-clock synchronous FIFO, parameters width and depth.
  - Ports: push, pop, din, dout, full, empty.
  - Instantiated once per source via generate.

## Test plan
- Single source 0 pushes (5,7,3'b101) → `plot` = 1 with x = 5, y = 7, colour = 5, exactly 2 edges after acceptance; `drop_cnt` stays 0.
- Two sources backlogged with 4 pixels each → output alternates src0, src1, src0, ... for 8 consecutive `plot` cycles.
- Source 1 pushes 9 pixels with no pop possible (sweep active, `FIFO_DEPTH` = 8) → `src_ready[1]` low after the 8th push; the 9th is held until the sweep ends.
- Push (320,0) and (0,240) → no `plot`, `drop_cnt` = 2; push (319,239) → plotted.
- `clear_req` with `clear_colour` = 3'b111 → 76800 consecutive plots ending at (319,239), then a one-cycle `clear_done` pulse; a second `clear_req` mid-sweep has no effect.
- Assert `resetn` = 0 mid-sweep with FIFOs non-empty → all outputs 0, `src_ready` all 1, `clear_busy` 0 immediately; the next push after release appears with 2-edge latency.
